// File: rtl/chi_tx_link_arbiter_pkg.sv
// chi_tx_link_arbiter_pkg: shared CHI link-layer types and limits
package chi_tx_link_arbiter_pkg;
  localparam int CHI_MAX_LCRD = 15;
  typedef enum logic [1:0] {LINK_STOP, LINK_RUN, LINK_RETURN} chi_link_state_e;
  typedef struct packed {
    logic [3:0]  qos;
    logic [10:0] tgt_id;
    logic [10:0] src_id;
    logic [11:0] txn_id;
    logic [6:0]  opcode;
    logic [47:0] addr;
  } request_flit_t;
endpackage

// File: rtl/chi_channel_inf.sv
// chi_channel_inf: CHI link channel, flit_pend/flit_v/flit forward and lcrd_v backward
interface chi_channel_inf #(
  parameter type DATA_T = chi_tx_link_arbiter_pkg::request_flit_t
);
  logic  flit_pend;
  logic  flit_v;
  DATA_T flit;
  logic  lcrd_v;
  modport tx (output flit_pend, output flit_v, output flit, input lcrd_v);
  modport rx (input flit_pend, input flit_v, input flit, output lcrd_v);
endinterface

// File: rtl/chi_rr_arbiter.sv
// chi_rr_arbiter: one-hot round-robin arbiter, priority starts after the last granted slot
module chi_rr_arbiter #(
  parameter int N = 4,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic [W-1:0] sel
);
  logic [W-1:0] ptr_q, ptr_d, idx;
  logic hit;
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr_q) + i) % N);
      if (req[idx]) begin
        sel = idx;
        hit = 1'b1;
      end
    end
    gnt = hit ? N'(1) << sel : '0;
    ptr_d = (advance && hit) ? (int'(sel) == N - 1 ? '0 : sel + W'(1)) : ptr_q;
  end
  always_ff @(posedge clk)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/chi_tx_link_arbiter.sv
// chi_tx_link_arbiter: credit-gated round-robin mux of N_REQ requesters onto one CHI TX channel
module chi_tx_link_arbiter
  import chi_tx_link_arbiter_pkg::*;
#(
  parameter type DATA_T = request_flit_t,
  parameter int N_REQ = 4,
  parameter int MAX_CRD = CHI_MAX_LCRD,
  localparam int CRD_W = $clog2(MAX_CRD + 1),
  localparam int SEL_W = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              link_en,
  input  logic [N_REQ-1:0]  req_valid,
  input  DATA_T             req_flit [N_REQ],
  output logic [N_REQ-1:0]  req_ready,
  chi_channel_inf.tx        tx,
  output logic [CRD_W-1:0]  crd_cnt,
  output logic              link_stopped,
  output logic              crd_ovf
);
  chi_link_state_e state_q, state_d;
  logic [CRD_W-1:0] crd_q, crd_d;
  logic flit_v_q, flit_v_d, ovf_q, ovf_d;
  DATA_T flit_q, flit_d;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic can_grant, granted, ret, send, crd_full;
  chi_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid & {N_REQ{can_grant}}),
    .advance (can_grant),
    .gnt     (gnt),
    .sel     (sel)
  );
  always_comb begin
    can_grant = state_q == LINK_RUN && crd_q != '0;
    ret = state_q == LINK_RETURN && crd_q != '0;
    granted = |gnt;
    send = granted || ret;
    crd_full = crd_q == CRD_W'(MAX_CRD);
    flit_d = granted ? req_flit[sel] : ret ? '0 : flit_q;
    flit_v_d = send;
    crd_d = (tx.lcrd_v && !send && !crd_full) ? crd_q + CRD_W'(1) :
            (!tx.lcrd_v && send) ? crd_q - CRD_W'(1) : crd_q;
    ovf_d = ovf_q || (tx.lcrd_v && !send && crd_full);
    state_d = state_q == LINK_STOP ? (link_en ? LINK_RUN : LINK_STOP) :
              state_q == LINK_RUN  ? (link_en ? LINK_RUN : LINK_RETURN) :
              (crd_q == '0 && !tx.lcrd_v) ? LINK_STOP : LINK_RETURN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= LINK_STOP;
      crd_q <= '0;
      flit_v_q <= 1'b0;
      flit_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crd_q <= crd_d;
      flit_v_q <= flit_v_d;
      flit_q <= flit_d;
      ovf_q <= ovf_d;
    end
  assign tx.flit_pend = send;
  assign tx.flit_v = flit_v_q;
  assign tx.flit = flit_q;
  assign req_ready = gnt;
  assign crd_cnt = crd_q;
  assign link_stopped = state_q == LINK_STOP;
  assign crd_ovf = ovf_q;
endmodule

// File: tb/tb_chi_tx_link_arbiter.sv
// tb_chi_tx_link_arbiter: directed plus random stimulus against a cycle-level behavioural model
module tb_chi_tx_link_arbiter;
  import chi_tx_link_arbiter_pkg::*;
  localparam int N = 4;
  localparam int MC = 15;
  localparam int M_STOP = 0, M_RUN = 1, M_RET = 2;
  logic clk = 1'b0, rst = 1'b1, link_en = 1'b0, lcrd_v = 1'b0;
  logic [N-1:0] req_valid = '0;
  request_flit_t req_flit [N];
  logic [N-1:0] req_ready;
  logic [3:0] crd_cnt;
  logic link_stopped, crd_ovf;
  int cmps = 0, errs = 0;
  int m_mode = M_STOP, m_crd = 0, m_rr = 0;
  request_flit_t m_flit = '0;
  bit m_v = 1'b0, m_ovf = 1'b0;
  chi_channel_inf #(.DATA_T(request_flit_t)) tx_if ();
  assign tx_if.lcrd_v = lcrd_v;
  chi_tx_link_arbiter #(.DATA_T(request_flit_t), .N_REQ(N), .MAX_CRD(MC)) dut (
    .clk          (clk),
    .rst          (rst),
    .link_en      (link_en),
    .req_valid    (req_valid),
    .req_flit     (req_flit),
    .req_ready    (req_ready),
    .tx           (tx_if),
    .crd_cnt      (crd_cnt),
    .link_stopped (link_stopped),
    .crd_ovf      (crd_ovf)
  );
  always #5 clk = ~clk;
  function automatic request_flit_t rand_flit();
    request_flit_t f;
    f.qos = 4'($urandom);
    f.tgt_id = 11'($urandom);
    f.src_id = 11'($urandom);
    f.txn_id = 12'($urandom);
    f.opcode = 7'($urandom_range(1, 127));
    f.addr = {16'($urandom), 32'($urandom)};
    return f;
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    int g;
    logic [N-1:0] eg;
    bit ret, snd;
    for (int k = 0; k < N; k++) req_flit[k] = rand_flit();
    #1;
    g = -1;
    if (m_mode == M_RUN && m_crd > 0)
      for (int k = 0; k < N; k++) begin
        int c = (m_rr + k) % N;
        if (g < 0 && ((req_valid >> c) & N'(1)) != '0) g = c;
      end
    ret = m_mode == M_RET && m_crd > 0;
    snd = g >= 0 || ret;
    eg = '0;
    if (g >= 0) eg = N'(1) << g;
    chk("req_ready", req_ready, eg);
    chk("flit_pend", tx_if.flit_pend, snd);
    if (rst) begin
      m_mode = M_STOP;
      m_crd = 0;
      m_rr = 0;
      m_flit = '0;
      m_v = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (g >= 0) begin
        m_flit = req_flit[2'(g)];
        m_rr = (g + 1) % N;
      end else if (ret) m_flit = '0;
      m_v = snd;
      if (m_mode == M_STOP && link_en) m_mode = M_RUN;
      else if (m_mode == M_RUN && !link_en) m_mode = M_RET;
      else if (m_mode == M_RET && m_crd == 0 && !lcrd_v) m_mode = M_STOP;
      m_crd = m_crd + int'(lcrd_v) - int'(snd);
      if (m_crd > MC) begin
        m_crd = MC;
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("flit_v", tx_if.flit_v, m_v);
    chk("flit", tx_if.flit, m_flit);
    chk("crd_cnt", crd_cnt, m_crd);
    chk("link_stopped", link_stopped, m_mode == M_STOP);
    chk("crd_ovf", crd_ovf, m_ovf);
  endtask
  task automatic set_crd(input int n);
    rst = 1'b0;
    link_en = 1'b1;
    for (int i = 0; i < 60 && (m_crd != n || m_mode != M_RUN); i++) begin
      lcrd_v = m_crd < n;
      req_valid = m_crd > n ? 4'b0001 : 4'b0000;
      step();
    end
    lcrd_v = 1'b0;
    req_valid = '0;
    chk("set_crd", crd_cnt, n);
  endtask
  initial begin
    for (int k = 0; k < N; k++) req_flit[k] = rand_flit();
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("reset_crd", crd_cnt, 0);
    chk("reset_stopped", link_stopped, 1);
    rst = 1'b0;
    link_en = 1'b1;
    lcrd_v = 1'b1;
    repeat (3) step();
    lcrd_v = 1'b0;
    req_valid = 4'b0001;
    repeat (5) step();
    chk("s1_drained", crd_cnt, 0);
    req_valid = '0;
    set_crd(15);
    req_valid = 4'b1111;
    repeat (9) step();
    chk("s2_flit_v", tx_if.flit_v, 1);
    req_valid = '0;
    set_crd(2);
    req_valid = 4'b0001;
    lcrd_v = 1'b1;
    step();
    chk("s3_same_cycle", crd_cnt, 2);
    req_valid = '0;
    lcrd_v = 1'b0;
    set_crd(15);
    lcrd_v = 1'b1;
    step();
    lcrd_v = 1'b0;
    chk("s3_saturate", crd_cnt, 15);
    chk("s3_ovf", crd_ovf, 1);
    set_crd(5);
    link_en = 1'b0;
    step();
    req_valid = 4'b1111;
    repeat (7) step();
    chk("s4_crd", crd_cnt, 0);
    chk("s4_stopped", link_stopped, 1);
    req_valid = '0;
    set_crd(4);
    link_en = 1'b0;
    repeat (2) step();
    lcrd_v = 1'b1;
    link_en = 1'b1;
    step();
    lcrd_v = 1'b0;
    for (int i = 0; i < 12 && !link_stopped; i++) step();
    chk("s5_stop", link_stopped, 1);
    step();
    chk("s5_run", link_stopped, 0);
    set_crd(8);
    req_valid = 4'b0001;
    step();
    chk("s6_flit_v", tx_if.flit_v, 1);
    rst = 1'b1;
    req_valid = '0;
    step();
    chk("s6_crd", crd_cnt, 0);
    chk("s6_flit_v_rst", tx_if.flit_v, 0);
    chk("s6_stopped", link_stopped, 1);
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 199) == 0;
      link_en = $urandom_range(0, 19) != 0;
      lcrd_v = $urandom_range(0, 2) == 0;
      req_valid = N'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
